// File: rtl/irq_dispatcher_if.sv
// irq_dispatcher_if: interrupt lines, per-core offer/ack/done handshake and top-level report
interface irq_dispatcher_if #(
  parameter int NUM_CORES = 4,
  parameter int NUM_INTERRUPTS = 16,
  parameter int ID_WIDTH = 4
);
  logic [NUM_INTERRUPTS-1:0] interrupts;
  logic [NUM_INTERRUPTS-1:0] irq_enable;
  logic [NUM_CORES-1:0] core_avail;
  logic [NUM_CORES-1:0] core_irq_valid;
  logic [NUM_CORES*ID_WIDTH-1:0] core_irq_id;
  logic [NUM_CORES-1:0] core_irq_ack;
  logic [NUM_CORES-1:0] core_irq_done;
  logic interrupt_ack;
  logic [ID_WIDTH-1:0] interrupt_id;
  logic [NUM_INTERRUPTS-1:0] irq_pending;
  logic [NUM_INTERRUPTS-1:0] irq_in_service;
  modport master (
    output interrupts, irq_enable, core_avail, core_irq_ack, core_irq_done,
    input core_irq_valid, core_irq_id, interrupt_ack, interrupt_id, irq_pending, irq_in_service
  );
  modport slave (
    input interrupts, irq_enable, core_avail, core_irq_ack, core_irq_done,
    output core_irq_valid, core_irq_id, interrupt_ack, interrupt_id, irq_pending, irq_in_service
  );
endinterface

// File: rtl/irq_dispatcher.sv
// irq_dispatcher: latches edge-triggered interrupts and dispatches them round-robin to cores
module irq_dispatcher #(
  parameter int NUM_CORES = 4,
  parameter int NUM_INTERRUPTS = 16,
  parameter int ID_WIDTH = 4,
  parameter int OFFER_TIMEOUT = 15
) (
  input logic clk,
  input logic rst_n,
  irq_dispatcher_if.slave bus
);
  localparam int CW = $clog2(NUM_CORES);
  // bit 0 of the state doubles as the registered core_irq_valid
  localparam logic [1:0] FREE = 2'b00, OFFERED = 2'b01, BUSY = 2'b10;
  logic [NUM_INTERRUPTS-1:0] prev, pending, in_service, edge_det, eligible;
  logic [NUM_INTERRUPTS-1:0] pend_set, pend_clr, svc_set, svc_clr;
  logic [1:0] st [NUM_CORES];
  logic [7:0] cnt [NUM_CORES];
  logic [ID_WIDTH-1:0] id [NUM_CORES];
  logic [CW-1:0] rr_ptr, sel_core, cand;
  logic [ID_WIDTH-1:0] sel_id, acc_id, int_id;
  logic [NUM_CORES-1:0] acc, wdraw, fin;
  logic any_line, any_core, disp, int_ack;
  function automatic logic [NUM_INTERRUPTS-1:0] onehot(input logic [ID_WIDTH-1:0] v);
    return NUM_INTERRUPTS'(1) << v;
  endfunction
  always_comb begin
    edge_det = bus.interrupts & ~prev & bus.irq_enable;
    eligible = pending & ~in_service;
    any_line = 1'b0;
    sel_id = '0;
    for (int i = NUM_INTERRUPTS - 1; i >= 0; i--)
      if (eligible[i]) begin
        any_line = 1'b1;
        sel_id = ID_WIDTH'(i);
      end
    any_core = 1'b0;
    sel_core = '0;
    cand = '0;
    // walk rr_ptr+NUM_CORES down to rr_ptr+1 so the nearest free core is written last
    for (int k = NUM_CORES; k >= 1; k--) begin
      cand = CW'((32'(rr_ptr) + 32'(k)) % NUM_CORES);
      if (st[cand] == FREE && bus.core_avail[cand]) begin
        any_core = 1'b1;
        sel_core = cand;
      end
    end
    disp = any_line & any_core;
    acc = '0;
    acc_id = '0;
    wdraw = '0;
    fin = '0;
    pend_set = edge_det;
    pend_clr = disp ? onehot(sel_id) : '0;
    svc_set = disp ? onehot(sel_id) : '0;
    svc_clr = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      if (st[c] == OFFERED && bus.core_irq_ack[c] && acc == '0) begin
        acc[c] = 1'b1;
        acc_id = id[c];
      end
      wdraw[c] = st[c] == OFFERED && !acc[c] && (cnt[c] == 8'd0 || !bus.core_avail[c]);
      fin[c] = st[c] == BUSY && bus.core_irq_done[c];
      svc_clr = svc_clr | ((wdraw[c] || fin[c]) ? onehot(id[c]) : '0);
      pend_set = pend_set | (wdraw[c] ? onehot(id[c]) : '0);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev <= '0;
      pending <= '0;
      in_service <= '0;
      rr_ptr <= CW'(NUM_CORES - 1);
      int_ack <= 1'b0;
      int_id <= '0;
      for (int c = 0; c < NUM_CORES; c++) begin
        st[c] <= FREE;
        cnt[c] <= '0;
        id[c] <= '0;
      end
    end else begin
      prev <= bus.interrupts;
      pending <= (pending & ~pend_clr) | pend_set;
      in_service <= (in_service & ~svc_clr) | svc_set;
      int_ack <= |acc;
      if (|acc) int_id <= acc_id;
      if (disp) rr_ptr <= sel_core;
      for (int c = 0; c < NUM_CORES; c++)
        if (disp && sel_core == CW'(c)) begin
          st[c] <= OFFERED;
          id[c] <= sel_id;
          cnt[c] <= 8'(OFFER_TIMEOUT);
        end else if (acc[c]) st[c] <= BUSY;
        else if (wdraw[c] || fin[c]) st[c] <= FREE;
        else if (st[c] == OFFERED && !bus.core_irq_ack[c]) cnt[c] <= cnt[c] - 8'd1;
    end
  always_comb
    for (int c = 0; c < NUM_CORES; c++) begin
      bus.core_irq_valid[c] = st[c][0];
      bus.core_irq_id[c*ID_WIDTH +: ID_WIDTH] = id[c];
    end
  assign bus.interrupt_ack = int_ack;
  assign bus.interrupt_id = int_id;
  assign bus.irq_pending = pending;
  assign bus.irq_in_service = in_service;
endmodule

// File: doc/irq_dispatcher.md
# irq_dispatcher

Distributes the shared interrupt lines among the CPU cores. It edge-detects and latches interrupt requests and selects the highest-priority pending request. It offers that request to an available core, chosen round-robin, and tracks each request through acknowledge and end-of-service. The block sits between the top-level `interrupts` input and the per-core interrupt ports. It produces the single top-level `interrupt_ack`/`interrupt_id` report.

## Interface
- `NUM_CORES`, 4, number of cores served (2..8).
- `NUM_INTERRUPTS`, 16, number of interrupt lines (≤ 2^ID_WIDTH).
- `ID_WIDTH`, 4, interrupt id width.
- `OFFER_TIMEOUT`, 15, cycles an unacknowledged offer is held before withdrawal (1..255).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock.
- `rst_n`  in  1  async active-low reset.
- `interrupts`  in  NUM_INTERRUPTS  level lines, synchronous to `clk`; a 0→1 transition is a request.
- `irq_enable`  in  NUM_INTERRUPTS  per-line enable; a disabled line's edge is dropped.
- `core_avail`  in  NUM_CORES  core can take interrupts.
- `core_irq_valid`  out  NUM_CORES  offer outstanding to core c.
- `core_irq_id`  out  NUM_CORES*ID_WIDTH  offered id; slice c is `[c*ID_WIDTH +: ID_WIDTH]`.
- `core_irq_ack`  in  NUM_CORES  core accepts its offer; level, held until valid drops.
- `core_irq_done`  in  NUM_CORES  single-cycle end-of-service pulse.
- `interrupt_ack`  out  1  one-cycle pulse when an ack is accepted.
- `interrupt_id`  out  ID_WIDTH  id of the accepted interrupt; valid with `interrupt_ack`, held otherwise.
- `irq_pending`  out  NUM_INTERRUPTS  pending register.
- `irq_in_service`  out  NUM_INTERRUPTS  in-service register.

## Operation
- Edge detect: `prev` register holds `interrupts` from the previous cycle.
  - `edge = interrupts & ~prev & irq_enable`.
- Pending:
  - Set by `edge`; cleared when the line is dispatched.
  - Set wins over clear in the same cycle.
- Eligible lines are `pending & ~in_service`. Priority is fixed: lowest index wins.
- Per-core FSM has states FREE, OFFERED and BUSY. All reset to FREE.
  - FREE→OFFERED: core selected for dispatch. Load id, set in_service[id], clear pending[id], load timeout counter with OFFER_TIMEOUT.
  - OFFERED→BUSY: ack accepted. `core_irq_valid` drops.
  - OFFERED→FREE (withdraw): counter reaches 0, or `core_avail[c]` low. Clear in_service[id] and set pending[id].
  - BUSY→FREE: `core_irq_done[c]`. Clear in_service[id].
  - `done` in FREE or OFFERED is ignored. `ack` outside OFFERED is ignored.
- Dispatch:
  - At most one dispatch per cycle, when any eligible line exists and any core is FREE with `core_avail`.
  - Core choice is round-robin: search starts at `rr_ptr+1` mod NUM_CORES. `rr_ptr` updates to the chosen core.
- Ack acceptance:
  - At most one per cycle, to the lowest-index core with OFFERED & ack. Other acking cores stay OFFERED.
  - Their timeout counters freeze while ack is held.
- Collision priority:
  - Ack acceptance beats withdraw in the same cycle.
  - A withdraw and a new edge on the same line leave pending set once.
  - `done` and a dispatch to the same core in the same cycle: the core goes FREE this cycle. Dispatch considers it the next cycle.
- A line that is in service may become pending again. It is not redispatched until its in_service bit clears.

## Timing
- Reset values:
  - `core_irq_valid`=0, `core_irq_id`=0, `interrupt_ack`=0, `interrupt_id`=0.
  - `irq_pending`=0, `irq_in_service`=0, `prev`=0, `rr_ptr`=NUM_CORES-1 (so core 0 is chosen first).
- Reset mid-operation: every outstanding offer and service is discarded immediately, with no ack pulse.
- All outputs are registered.
- Latencies, with the rising edge of `interrupts` sampled at edge N:
  - `irq_pending` high at N+1.
  - `core_irq_valid` high at N+2.
- Ack sampled at edge M: `core_irq_valid` low, `interrupt_ack` high and `interrupt_id` valid, all at M+1.
- Timeout: valid stays high for exactly OFFER_TIMEOUT+1 cycles when no ack arrives. It drops and pending reasserts in the same cycle.
- `core_avail` drop sampled at edge K: valid low at K+1.
- `done` sampled at edge D: in_service bit clear at D+1. The earliest redispatch of that line or core is visible at D+2.

## Test plan
- Single request: rising edge on line 5 with all cores available. Required: pending[5] at +1; `core_irq_valid[0]`=1 with id 5 at +2; ack → `interrupt_ack` pulse with `interrupt_id`=5; done → `irq_in_service`=0.
- Priority and round-robin: lines 3, 9 and 1 rise together. Required: three consecutive dispatches to cores 0, 1, 2 in that order, with ids 1, 3, 9.
- Timeout: offer line 7 to core 0 and never ack, OFFER_TIMEOUT=15. Required: valid high for 16 cycles, then pending[7]=1, then re-offer to core 1.
- Simultaneous acks: cores 0 and 2 ack in the same cycle. Required: core 0 accepted first (`interrupt_id` = its id), core 2 accepted on the next cycle; two separate pulses.
- Re-raise during service: line 4 BUSY on core 1 and line 4 rises again. Required: pending[4]=1 with no redispatch until done; after done, redispatch of line 4 to the next round-robin core.
- Masking and reset: an edge with `irq_enable[6]`=0 leaves pending unchanged. Asserting `rst_n` low while offers are outstanding clears all valids, pending bits and in-service bits immediately.
